// File: rtl/adc_128s.sv
// ADC128S-style SPI slave: pipelined 3-bit channel select, 12-bit reply.
// Define ADC128S_MISO_TRISTATE_EN to float MISO while slave select is high.
module adc_128s (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  input  logic [11:0] batt_set
);

  logic [2:0]  ss_q;
  logic [2:0]  sclk_q;
  logic [2:0]  mosi_q;
  logic [1:0]  prime;
  logic        armed;
  logic        active;
  logic [4:0]  cnt;
  logic [15:0] rx;
  logic [15:0] tx;
  logic [2:0]  ch;
  logic [11:0] value;

  logic ss_fall;
  logic ss_rise;
  logic ss_edge;
  logic sclk_rise;
  logic sclk_fall;
  logic frame_start;
  logic done;

  assign ss_fall     = ss_q[2] & ~ss_q[1];
  assign ss_rise     = ~ss_q[2] & ss_q[1];
  assign ss_edge     = ss_fall | ss_rise;
  assign sclk_rise   = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall   = sclk_q[2] & ~sclk_q[1];
  assign frame_start = ss_fall & armed;
  assign done        = (cnt == 5'd16);

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 3'b111;
      prime  <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[1:0], MOSI};
      prime  <= {prime[0], 1'b1};
    end
  end

  // A frame may only start once a genuine post-reset high on SS_n was seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (prime[1] & ss_q[1]) begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    value = 12'h000;
    case (ch)
      3'd0:    value = lft_cell_set;
      3'd4:    value = rght_cell_set;
      3'd5:    value = batt_set;
      default: value = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= 5'd0;
      rx     <= 16'h0000;
      tx     <= 16'h0000;
      ch     <= 3'd0;
    end else if (frame_start) begin
      active <= 1'b1;
      cnt    <= 5'd0;
      rx     <= 16'h0000;
      tx     <= {4'b0000, value};
    end else if (ss_rise) begin
      active <= 1'b0;
      cnt    <= 5'd0;
      if (active & done) begin
        ch <= rx[13:11];
      end
    end else if (active & ~ss_edge) begin
      if (sclk_rise & ~done) begin
        rx  <= {rx[14:0], mosi_q[2]};
        cnt <= cnt + 5'd1;
      end
      // The leading fall precedes any rise; holding it keeps bit 15 valid.
      if (sclk_fall & (cnt != 5'd0)) begin
        tx <= {tx[14:0], 1'b0};
      end
    end
  end

`ifdef ADC128S_MISO_TRISTATE_EN
  assign MISO = ss_q[1] ? 1'bz : tx[15];
`else
  assign MISO = ss_q[1] ? 1'b0 : tx[15];
`endif

endmodule

// File: tb/tb_adc_128s.sv
// Directed bench for adc_128s: table of address/read frame pairs
// plus hand sequences for reset, abort, late set change and mid-frame reset.
module tb_adc_128s;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] lft_cell_set;
  logic [11:0] rght_cell_set;
  logic [11:0] batt_set;

  int passed;
  int total;

  adc_128s dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .lft_cell_set (lft_cell_set),
    .rght_cell_set(rght_cell_set),
    .batt_set     (batt_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] batt;
    logic [15:0] exp_addr;
    logic [15:0] exp_read;
  } vec_t;

  vec_t vecs[8];

  task automatic check16(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_idle(input string name);
    total++;
`ifdef ADC128S_MISO_TRISTATE_EN
    if (MISO === 1'bz) passed++;
    else $display("FAIL %s: MISO got %b expected z", name, MISO);
`else
    if (MISO === 1'b0) passed++;
    else $display("FAIL %s: MISO got %b expected 0", name, MISO);
`endif
  endtask

  // nrise: SCLK cycles sent; rst_after: pulse rst after that rise (0 = none)
  task automatic frame(input logic [15:0] cmd, input int nrise,
                       input int rst_after, input logic chg,
                       input logic [11:0] nb, output logic [15:0] rep);
    rep = 16'h0000;
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    if (chg) batt_set = nb;
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (6) @(negedge clk);
      rep = {rep[14:0], MISO};
      SCLK = 1'b1;
      repeat (6) @(negedge clk);
      if (rst_after == i + 1) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [15:0] rep;

  initial begin
    passed = 0;
    total  = 0;
    vecs[0] = '{16'h2800, 12'h111, 12'h222, 12'h9A5, 16'h0111, 16'h09A5};
    vecs[1] = '{16'h2000, 12'h111, 12'h3FF, 12'h9A5, 16'h0111, 16'h03FF};
    vecs[2] = '{16'h1000, 12'h111, 12'h3FF, 12'h9A5, 16'h0111, 16'h0000};
    vecs[3] = '{16'h0000, 12'h123, 12'h456, 12'h789, 16'h0123, 16'h0123};
    vecs[4] = '{16'h0800, 12'hFFF, 12'h456, 12'h789, 16'h0FFF, 16'h0000};
    vecs[5] = '{16'h3800, 12'h5A5, 12'h456, 12'h789, 16'h05A5, 16'h0000};
    vecs[6] = '{16'hE7FF, 12'h001, 12'hC3C, 12'h789, 16'h0001, 16'h0C3C};
    vecs[7] = '{16'h2BFF, 12'h002, 12'hC3C, 12'hE01, 16'h0002, 16'h0E01};

    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    lft_cell_set  = 12'hABC;
    rght_cell_set = 12'h000;
    batt_set      = 12'h000;
    repeat (3) @(negedge clk);
    check_idle("reset_idle");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("post_reset_idle");

    frame(16'h0000, 16, 0, 1'b0, 12'h0, rep);
    check16("first_frame_ch0", rep, 16'h0ABC);
    check_idle("idle_after_frame");

    foreach (vecs[i]) begin
      lft_cell_set  = vecs[i].lft;
      rght_cell_set = vecs[i].rght;
      batt_set      = vecs[i].batt;
      frame(vecs[i].cmd, 16, 0, 1'b0, 12'h0, rep);
      check16($sformatf("vec%0d_addr", i), rep, vecs[i].exp_addr);
      frame(16'h0000, 16, 0, 1'b0, 12'h0, rep);
      check16($sformatf("vec%0d_read", i), rep, vecs[i].exp_read);
    end

    // abort leaves the channel alone
    lft_cell_set  = 12'h0F0;
    rght_cell_set = 12'h3FF;
    batt_set      = 12'h9A5;
    frame(16'h2800, 16, 0, 1'b0, 12'h0, rep);
    frame(16'h2000, 8, 0, 1'b0, 12'h0, rep);
    frame(16'h0000, 16, 0, 1'b0, 12'h0, rep);
    check16("abort_keeps_ch5", rep, 16'h09A5);

    // set value is captured at the frame start
    frame(16'h2800, 16, 0, 1'b0, 12'h0, rep);
    frame(16'h0000, 16, 0, 1'b1, 12'h123, rep);
    check16("late_batt_change", rep, 16'h09A5);

    // mid-frame reset returns to channel 0
    frame(16'h2800, 16, 0, 1'b0, 12'h0, rep);
    frame(16'h2800, 16, 8, 1'b0, 12'h0, rep);
    check_idle("idle_after_rst_frame");
    frame(16'h0000, 16, 0, 1'b0, 12'h0, rep);
    check16("rst_midframe_ch0", rep, 16'h00F0);
    check_idle("final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_128s.md
ADC_128S -- requirements
Module: adc_128s

Interface
- REQ-001: The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
- REQ-002: The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-003: The block SHALL have port SS_n, input, 1 bit: SPI slave select, active-low, asynchronous to clk.
- REQ-004: The block SHALL have port SCLK, input, 1 bit: SPI clock, idle high, asynchronous to clk.
- REQ-005: The block SHALL have port MOSI, input, 1 bit: serial command from the master, MSB first.
- REQ-006: The block SHALL have port MISO, output, 1 bit: serial conversion result to the master, MSB first.
- REQ-007: The block SHALL have port lft_cell_set, input, 12 bits: value returned for channel 0.
- REQ-008: The block SHALL have port rght_cell_set, input, 12 bits: value returned for channel 4.
- REQ-009: The block SHALL have port batt_set, input, 12 bits: value returned for channel 5.

Function
- REQ-010: SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer, plus one extra flop for edge detection. The master SHALL hold SCLK high and low for at least 4 clk periods each.
- REQ-011: A frame SHALL start on a detected SS_n falling edge and end on a detected SS_n rising edge. A full frame is exactly 16 SCLK cycles.
- REQ-012: Each frame is full duplex: 16 bits in on MOSI, 16 bits out on MISO.
- REQ-013: MOSI SHALL be sampled on each detected SCLK rising edge while SS_n is low, into a 16-bit receive shift register, MSB first.
- REQ-014: The 16-bit transmit shift register SHALL shift left on each detected SCLK falling edge while SS_n is low. MISO SHALL equal its MSB.
- REQ-015: On frame start, the transmit register SHALL load {4'b0000, value}, where value is the channel selected by the channel register.
  - The set input SHALL be sampled in the same clk cycle as the load.
  - MISO SHALL therefore show bit 15 before the first SCLK rise.
- REQ-016: Channel map: ch0 = lft_cell_set, ch4 = rght_cell_set, ch5 = batt_set. Channels 1, 2, 3, 6 and 7 SHALL return 12'h000.
- REQ-017: The channel register (3 bits) SHALL update only at the end of a complete frame, to received bits [13:11]. Bits 15:14 and 10:0 are don't-care.
- REQ-018: The reply in frame N SHALL be for the channel addressed in frame N-1 (pipelined).
  - A two-frame master sequence (address, then read) therefore returns the addressed channel in the second frame.
- REQ-019: A bit counter (5 bits) SHALL count SCLK rising edges within a frame.
  - SCLK rising edges after the 16th SHALL be ignored.
  - SCLK falling edges after the 16th SHALL shift in 0.
- REQ-020: Aborted frame (SS_n rises with fewer than 16 rising edges): the channel register SHALL be unchanged and the counter SHALL clear.
- REQ-021: An SCLK edge coincident with a detected SS_n edge SHALL be ignored.
- REQ-022: While SS_n is high, MISO SHALL be as defined in Configuration.

Reset
- REQ-023: On rst, the following SHALL clear to 0:
  - channel register,
  - bit counter,
  - shift registers.
- REQ-024: On rst, the synchronizers SHALL preset to 1 (idle), and MISO SHALL take its idle value.
- REQ-025: rst asserted mid-frame SHALL abort the frame with no channel update. Slave logic SHALL ignore the remaining SCLK edges of that frame until SS_n is seen high, then low again.
- REQ-026: The first frame after reset SHALL return channel 0 (lft_cell_set).

Configuration
- REQ-027: With macro ADC128S_MISO_TRISTATE_EN defined, MISO SHALL be high-Z whenever the synchronized SS_n is high.
- REQ-028: Without ADC128S_MISO_TRISTATE_EN, MISO SHALL be driven 0 whenever the synchronized SS_n is high.
- REQ-029: In-frame behaviour SHALL be identical with and without the macro.

Verification
- REQ-030: Reset, then one frame with MOSI word 16'h0000 and lft_cell_set = 12'hABC -> MISO returns 16'h0ABC.
- REQ-031: Frame 16'h2800 (ch5), then frame 16'h2800, with batt_set = 12'h9A5 -> second reply is 16'h09A5.
- REQ-032: Frame 16'h2000 (ch4), then a read frame, with rght_cell_set = 12'h3FF -> reply 16'h03FF. Address ch2 instead -> reply 16'h0000.
- REQ-033: Address ch5, then abort a frame addressing ch4 after 8 SCLKs, then a full read frame -> batt_set value returned (channel unchanged).
- REQ-034: Change batt_set after frame start -> reply carries the value present at SS_n fall.
- REQ-035: Assert rst mid-frame -> channel returns to 0.
  - With ADC128S_MISO_TRISTATE_EN defined, MISO is Z while SS_n is high.
  - Without the macro, MISO is 0 while SS_n is high.
